cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Miss-handling controller for the 2-way direct-mapped-per-way cache. Sits between CPU request and the cache
//  arrays and four-banked main memory. Compares on each request; on a miss, writes back a dirty victim
//  (4 words), then fills the line (4 words), then replays the access. Its state/counter flops are plain
//  clocked register instances fed by this block's next-state logic.
// PARAMETERS
//  ADDR_W   16  address width; tag/index/offset = 5/8/3 bits
//  DATA_W   16  data word width
//  MEM_LAT  2   cycles from mem_rd issue to mem_data_out valid
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  req_rd         in   1       CPU read request (level, held until done)
//  req_wr         in   1       CPU write request (level, held until done)
//  req_addr       in   ADDR_W  request address, held until done
//  cache_hit      in   1       cache array: tag match and valid (comp mode)
//  cache_dirty    in   1       cache array: selected line dirty
//  cache_tag_out  in   5       cache array: victim line tag
//  mem_stall      in   1       memory bank busy; issue this cycle refused
//  cache_en       out  1       cache array enable
//  cache_comp     out  1       cache array compare mode
//  cache_write    out  1       cache array write
//  cache_offset   out  3       word offset to cache ({cnt,1'b0} during WB/FILL)
//  cache_sel_mem  out  1       1: cache data_in from memory; 0: from CPU
//  mem_rd         out  1       memory read issue
//  mem_wr         out  1       memory write issue
//  mem_addr       out  ADDR_W  memory address
//  done           out  1       one-cycle pulse: access complete
//  stall          out  1       CPU stall, high from miss detect until done
//  err            out  1       one-cycle pulse: req_rd & req_wr together
// BEHAVIOUR
//  Reset: state IDLE, counters 0; every output 0.
//  States: IDLE, COMP, WB, FILL, FWAIT, REPLAY.
//  IDLE: req_rd|req_wr -> COMP same edge; both high -> err pulse, treated as write.
//  COMP: cache_en=cache_comp=1, cache_write=req_wr. hit -> done=1, ->IDLE (hit latency 1 cycle after IDLE).
//    miss & dirty -> WB, cnt=0; miss & clean -> FILL, cnt=0; stall=1 from miss onward.
//  WB: word cnt: cache_en=1 (read), mem_wr=1, mem_addr={cache_tag_out,index,cnt,1'b0}.
//    mem_stall: hold cnt, re-issue next cycle. cnt==3 accepted -> FILL, cnt=0.
//  FILL: mem_rd=1, mem_addr={req tag,index,cnt,1'b0}; accepted issue increments cnt; stall holds.
//    Each accepted issue tagged in MEM_LAT-deep shift pipe; pipe output at cycle t+MEM_LAT drives
//    cache_write=1, cache_sel_mem=1, cache_comp=0, cache_offset=returned word's offset, valid=1.
//    cnt==3 accepted -> FWAIT. FWAIT: drain pipe; pipe empty -> REPLAY.
//  REPLAY: same as COMP with sel_mem=0; access now hits; done=1, stall=0 next, ->IDLE.
//  Clean miss latency, no stalls: COMP(1)+FILL(4)+FWAIT(2)+REPLAY(1) = 8 cycles.
//  Counter: 2-bit, wraps 3->0 only on state exit; never wraps in-state.
//  Write/issue collision: a fill write-back and new issue in same cycle both proceed (separate ports).
//  Reset mid-operation: next edge -> IDLE, pipe flushed, in-flight memory data ignored, no done.
//  Request dropped mid-miss (protocol violation): controller completes the fill, done still pulses.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds outputs hit_cnt[15:0], miss_cnt[15:0], wb_cnt[15:0]; increment on
//  COMP hit, COMP miss, WB entry; saturate at 16'hFFFF; clear on rst.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared header cache_ctrl_defs.v: state encodings (3-bit), TAG_W/IDX_W/OFF_W, MEM_LAT default.
//  Sub-module fill_pipe: MEM_LAT-deep valid+offset shift register tracking in-flight reads.
//  State, cnt and stats held in clocked register instances; all next-state logic combinational here.
// TESTING
//  Read hit: req_rd, addr 16'h0124, cache_hit=1 -> done at cycle 2, stall never high, no mem traffic.
//  Clean read miss: addr 16'h1A08, hit=0, dirty=0 -> mem_rd at 16'h1A08/0A/0C/0E consecutive,
//    cache writes offsets 0,2,4,6 two cycles later, done at cycle 8.
//  Dirty write miss: victim tag 5'h03 -> 4 mem_wr to {5'h03,idx,off} first, then fill, replay writes CPU data.
//  mem_stall for 3 cycles on second fill issue -> issue repeats same addr, done delayed 3 cycles.
//  rst asserted in FWAIT -> next cycle all outputs 0, state IDLE; late memory data causes no cache write.
//  req_rd & req_wr together -> err pulse, write performed; CACHE_STATS_EN build: counters match events.

Source files
------------

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared geometry, state encoding and helpers for the cache miss-handling controller.
package cache_fill_ctrl_pkg;

  localparam int TAG_W       = 5;
  localparam int IDX_W       = 8;
  localparam int OFF_W       = 3;
  localparam int LINE_ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int MEM_LAT_DEF = 2;
  localparam int STAT_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COMP   = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_FWAIT  = 3'd4,
    S_REPLAY = 3'd5
  } state_t;

  // Lines are four 16-bit words on even byte offsets, so word n sits at offset {n,1'b0}.
  function automatic logic [LINE_ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [IDX_W-1:0] idx,
                                                       input logic [1:0]       word);
    return {tag, idx, word, 1'b0};
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_fill_pipe.sv
// Tracks in-flight fill reads: a MEM_LAT-deep valid+offset shift register whose
// output marks the cycle a returned memory word must be written into the cache.
module cache_fill_ctrl_fill_pipe
  import cache_fill_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [OFF_W-1:0] push_off,
  output logic             out_valid,
  output logic [OFF_W-1:0] out_off,
  output logic             pending
);

  logic [MEM_LAT-1:0] vld;
  logic [OFF_W-1:0]   off_q [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) off_q[i] <= '0;
    end else begin
      vld[0]   <= push;
      off_q[0] <= push_off;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld[i]   <= vld[i-1];
        off_q[i] <= off_q[i-1];
      end
    end
  end

  assign out_valid = vld[MEM_LAT-1];
  assign out_off   = off_q[MEM_LAT-1];

  // Reads still travelling behind the stage that is being written this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) pending = pending | vld[i];
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: compare, dirty write-back, 4-word line fill, replay.
// Build option CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic [TAG_W-1:0]  cache_tag_out,
  input  logic              mem_stall,
  output logic              cache_en,
  output logic              cache_comp,
  output logic              cache_write,
  output logic [OFF_W-1:0]  cache_offset,
  output logic              cache_sel_mem,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done,
  output logic              stall,
  output logic              err
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt,
  output logic [STAT_W-1:0] wb_cnt
`endif
);

  state_t             state;
  logic [1:0]         cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               is_wr;
  logic               fill_push;
  logic               fill_valid;
  logic               fill_pending;
  logic [OFF_W-1:0]   fill_off;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;

  assign req_tag   = addr_q[OFF_W+IDX_W +: TAG_W];
  assign req_idx   = addr_q[OFF_W +: IDX_W];
  assign fill_push = (state == S_FILL) && !mem_stall;

  cache_fill_ctrl_fill_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_fill_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (fill_push),
    .push_off  ({cnt, 1'b0}),
    .out_valid (fill_valid),
    .out_off   (fill_off),
    .pending   (fill_pending)
  );

  // The request is captured on acceptance so a miss can finish even if the CPU drops it.
  // A hit's done shows up in the following IDLE cycle, while the CPU still holds the
  // request, so IDLE ignores requests while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      is_wr  <= 1'b0;
      done   <= 1'b0;
      stall  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((req_rd || req_wr) && !done) begin
            state  <= S_COMP;
            addr_q <= req_addr;
            is_wr  <= req_wr;
            err    <= req_rd && req_wr;
          end
        end
        S_COMP: begin
          if (cache_hit) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= cache_dirty ? S_WB : S_FILL;
            cnt   <= '0;
            stall <= 1'b1;
          end
        end
        S_WB: begin
          if (!mem_stall) begin
            if (cnt == 2'd3) begin
              state <= S_FILL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_FILL: begin
          if (!mem_stall) begin
            if (cnt == 2'd3) begin
              state <= S_FWAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_FWAIT: begin
          // The replay is known to hit, so done is raised for the REPLAY cycle itself.
          if (!fill_pending) begin
            state <= S_REPLAY;
            done  <= 1'b1;
          end
        end
        S_REPLAY: begin
          state <= S_IDLE;
          stall <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cache_en      = 1'b0;
    cache_comp    = 1'b0;
    cache_write   = 1'b0;
    cache_offset  = '0;
    cache_sel_mem = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    case (state)
      S_COMP, S_REPLAY: begin
        cache_en     = 1'b1;
        cache_comp   = 1'b1;
        cache_write  = is_wr;
        cache_offset = addr_q[OFF_W-1:0];
      end
      S_WB: begin
        cache_en     = 1'b1;
        cache_offset = {cnt, 1'b0};
        mem_wr       = 1'b1;
        mem_addr     = word_addr(cache_tag_out, req_idx, cnt);
      end
      S_FILL: begin
        cache_offset = {cnt, 1'b0};
        mem_rd       = 1'b1;
        mem_addr     = word_addr(req_tag, req_idx, cnt);
      end
      default: ;
    endcase
    // Returning fill data uses the cache data port while memory takes the next issue.
    if (fill_valid) begin
      cache_en      = 1'b1;
      cache_comp    = 1'b0;
      cache_write   = 1'b1;
      cache_sel_mem = 1'b1;
      cache_offset  = fill_off;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (state == S_COMP) begin
      if (cache_hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end else begin
        miss_cnt <= sat_inc(miss_cnt);
        if (cache_dirty) wb_cnt <= sat_inc(wb_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: expected memory issues, fill writes and done
// cycles are queued at stimulus time and popped as the controller produces them.
module tb_cache_fill_ctrl;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [15:0] req_addr;
  logic        cache_hit, cache_dirty;
  logic [4:0]  cache_tag_out;
  logic        mem_stall = 1'b0;
  logic        cache_en, cache_comp, cache_write, cache_sel_mem;
  logic [2:0]  cache_offset;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic        done, stall, err;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
  int          exp_hit = 0, exp_miss = 0, exp_wb = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_exp_t    mem_exp [$];
  logic [2:0]  fill_exp [$];
  int          ret_cycle [$];
  int          done_exp [$];
  int          done_count = 0;
  int          fill_accepts = 0;
  int          stall_idx = -1;
  int          stall_left = 0;
  int          stall_cycles = 0;
  int          err_cycles = 0;
  bit          cur_miss = 1'b0;
  bit          cur_wr = 1'b0;

  logic [27:0] outs;
  assign outs = {cache_en, cache_comp, cache_write, cache_offset, cache_sel_mem,
                 mem_rd, mem_wr, mem_addr, done, stall, err};

  cache_fill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_rd        (req_rd),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .cache_hit     (cache_hit),
    .cache_dirty   (cache_dirty),
    .cache_tag_out (cache_tag_out),
    .mem_stall     (mem_stall),
    .cache_en      (cache_en),
    .cache_comp    (cache_comp),
    .cache_write   (cache_write),
    .cache_offset  (cache_offset),
    .cache_sel_mem (cache_sel_mem),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .done          (done),
    .stall         (stall),
    .err           (err)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Memory/stall model and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    mem_exp_t e;
    mem_stall = (stall_left > 0) && (mem_rd === 1'b1) && (fill_accepts == stall_idx);
    if (mem_stall) stall_left--;
    if (stall === 1'b1) stall_cycles++;
    if (err === 1'b1) err_cycles++;
    if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
      if (mem_exp.size() == 0) begin
        checkOutput("mem_unexp", {30'd0, mem_rd, mem_wr}, 32'd0);
      end else begin
        e = mem_exp[0];
        checkOutput(mem_stall ? "mem_reissue" : "mem_issue",
                    {14'd0, mem_rd, mem_wr, mem_addr}, {14'd0, !e.wr, e.wr, e.addr});
        if (!mem_stall) begin
          void'(mem_exp.pop_front());
          if (mem_rd === 1'b1) begin
            ret_cycle.push_back(cyc + 2);
            fill_accepts++;
          end
        end
      end
    end
    if (cache_write === 1'b1 && cache_sel_mem === 1'b1) begin
      if (fill_exp.size() == 0 || ret_cycle.size() == 0) begin
        checkOutput("fill_unexp", {31'd0, cache_write}, 32'd0);
      end else begin
        checkOutput("fill_off", {29'd0, cache_offset}, {29'd0, fill_exp.pop_front()});
        checkOutput("fill_cycle", cyc, ret_cycle.pop_front());
        checkOutput("fill_ctl", {30'd0, cache_en, cache_comp}, 32'd2);
      end
    end
    if (done === 1'b1) begin
      done_count++;
      if (done_exp.size() == 0) begin
        checkOutput("done_unexp", 32'd1, 32'd0);
      end else begin
        checkOutput("done_cycle", cyc, done_exp.pop_front());
        checkOutput("done_ctl", {28'd0, cache_en, cache_comp, cache_write, cache_sel_mem},
                    cur_miss ? {28'd0, 1'b1, 1'b1, cur_wr, 1'b0} : 32'd0);
      end
    end
  end

  task automatic queueLine(input logic [15:0] addr, input bit dirty, input logic [4:0] vtag);
    logic [1:0] w;
    if (dirty)
      for (int i = 0; i < 4; i++) begin
        w = i[1:0];
        mem_exp.push_back('{wr: 1'b1, addr: {vtag, addr[10:3], w, 1'b0}});
      end
    for (int i = 0; i < 4; i++) begin
      w = i[1:0];
      mem_exp.push_back('{wr: 1'b0, addr: {addr[15:11], addr[10:3], w, 1'b0}});
      fill_exp.push_back({w, 1'b0});
    end
  endtask

  task automatic flushQueues();
    mem_exp.delete();
    fill_exp.delete();
    ret_cycle.delete();
    done_exp.delete();
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input bit hit, input bit dirty, input logic [4:0] vtag,
                               input int st_idx, input int st_len);
    int start, exp_done, d0;
    bit got;
    cur_miss = !hit;
    cur_wr   = wr;
    if (!hit) queueLine(addr, dirty, vtag);
`ifdef CACHE_STATS_EN
    if (hit) exp_hit++;
    else begin
      exp_miss++;
      if (dirty) exp_wb++;
    end
`endif
    @(posedge clk); #1;
    start = cyc;
    d0 = done_count;
    stall_cycles = 0; err_cycles = 0; fill_accepts = 0;
    stall_idx = st_idx; stall_left = hit ? 0 : st_len;
    req_rd = rd; req_wr = wr; req_addr = addr;
    cache_hit = hit; cache_dirty = dirty; cache_tag_out = vtag;
    exp_done = hit ? start + 2 : start + 8 + (dirty ? 4 : 0) + st_len;
    done_exp.push_back(exp_done);
    @(negedge clk); @(negedge clk);
    checkOutput("comp_ctl", {27'd0, cache_en, cache_comp, cache_write, cache_sel_mem, err},
                {27'd0, 1'b1, 1'b1, wr, 1'b0, rd & wr});
    checkOutput("comp_off", {29'd0, cache_offset}, {29'd0, addr[2:0]});
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (done_count > d0) got = 1'b1;
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
    #1;
    req_rd = 1'b0; req_wr = 1'b0; cache_hit = 1'b0; cache_dirty = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("stall_cycles", stall_cycles, hit ? 0 : exp_done - start - 1);
    checkOutput("err_cycles", err_cycles, (rd && wr) ? 1 : 0);
    checkOutput("queues_empty", mem_exp.size() + fill_exp.size() + ret_cycle.size() + done_exp.size(), 0);
    flushQueues();
    stall_idx = -1; stall_left = 0;
  endtask

  task automatic applyMidReset(input logic [15:0] addr);
    int d0;
    bit got;
    cur_miss = 1'b1;
    cur_wr   = 1'b0;
    queueLine(addr, 1'b0, 5'h00);
    @(posedge clk); #1;
    d0 = done_count;
    fill_accepts = 0; stall_idx = -1; stall_left = 0;
    req_rd = 1'b1; req_wr = 1'b0; req_addr = addr; cache_hit = 1'b0; cache_dirty = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      if (fill_accepts == 4) got = 1'b1;
    end
    checkOutput("rst_fill_issued", {31'd0, got}, 32'd1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_rd = 1'b0;
    flushQueues();
`ifdef CACHE_STATS_EN
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
`endif
    @(negedge clk);
    checkOutput("rst_outs", {4'd0, outs}, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("rst_no_done", done_count - d0, 0);
  endtask

  initial begin
    logic [15:0] ra;
    bit rh, rdy, rwr;
    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0;
    cache_hit = 1'b0; cache_dirty = 1'b0; cache_tag_out = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outs", {4'd0, outs}, 32'd0);

    $display("[TB] read hit / clean miss / dirty write miss / stalled fill / err");
    applyStimulus(1'b1, 1'b0, 16'h0124, 1'b1, 1'b0, 5'h00, -1, 0);
    applyStimulus(1'b1, 1'b0, 16'h1A08, 1'b0, 1'b0, 5'h00, -1, 0);
    applyStimulus(1'b0, 1'b1, 16'h2B30, 1'b0, 1'b1, 5'h03, -1, 0);
    applyStimulus(1'b1, 1'b0, 16'h7C1E, 1'b0, 1'b0, 5'h00, 1, 3);
    applyStimulus(1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 5'h00, -1, 0);

    for (int i = 0; i < 4; i++) begin
      ra  = 16'($urandom);
      rh  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      rwr = 1'($urandom_range(0, 1));
      applyStimulus(!rwr, rwr, ra, rh, rdy, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] reset during fill drain");
    applyMidReset(16'h1A08);
    applyStimulus(1'b0, 1'b1, 16'h3456, 1'b1, 1'b0, 5'h00, -1, 0);

`ifdef CACHE_STATS_EN
    checkOutput("hit_cnt", {16'd0, hit_cnt}, exp_hit);
    checkOutput("miss_cnt", {16'd0, miss_cnt}, exp_miss);
    checkOutput("wb_cnt", {16'd0, wb_cnt}, exp_wb);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
